// File: rtl/axi4_wr_burst_engine.sv
// axi4_wr_burst_engine: AXI4 write slave expanding AW/W bursts into per-beat memory writes with a B response FIFO
module axi4_wr_burst_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int B_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]              aw_len,
  input  logic [2:0]              aw_size,
  input  logic [1:0]              aw_burst,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [1:0]              b_resp,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready
);
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_WRAP = 2'b10, BURST_RSVD = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH/8));
  localparam int PW = $clog2(B_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(B_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  typedef enum logic {IDLE, DATA} state_t;
  state_t r_state, w_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [ID_WIDTH+1:0]   r_fifo [B_DEPTH];
  logic [PW-1:0]         r_wp, r_rp;
  logic [PW:0]           r_bcnt;
  logic w_aw_hs, w_w_hs, w_push, w_pop, w_aw_err;
  logic [ADDR_WIDTH-1:0] w_aw_mask, w_bytes, w_total, w_next_addr;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next   = r_state;
    aw_ready = ~rst & (r_state == IDLE) & (r_bcnt < DEPTH);
    w_ready  = (r_state == DATA) & (mem_ready | r_err);
    if (aw_valid & aw_ready) w_next = DATA;
    if (w_valid & w_ready & w_last) w_next = IDLE;
  end
  assign w_aw_hs   = aw_valid & aw_ready;
  assign w_w_hs    = w_valid & w_ready;
  assign w_push    = w_w_hs & w_last;
  assign w_pop     = b_valid & b_ready;
  assign w_aw_mask = (ONE << aw_size) - ONE;
  assign w_aw_err  = (aw_burst == BURST_RSVD) | (aw_size > SIZE_MAX) |
                     ((aw_burst == BURST_WRAP) & !(aw_len inside {8'd1, 8'd3, 8'd7, 8'd15})) |
                     ((aw_burst == BURST_WRAP) & (|(aw_addr & w_aw_mask)));
  assign w_bytes   = ONE << r_size;
  assign w_total   = (ADDR_WIDTH'(r_len) + ONE) << r_size;
  assign w_next_addr = (r_burst == BURST_FIXED) ? r_addr :
                       (r_burst == BURST_WRAP)  ? ((r_addr & ~(w_total - ONE)) | ((r_addr + w_bytes) & (w_total - ONE))) :
                                                  ((r_addr & ~(w_bytes - ONE)) + w_bytes);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (w_aw_hs) begin
      r_id    <= aw_id;
      r_addr  <= aw_addr;
      r_len   <= aw_len;
      r_size  <= aw_size;
      r_burst <= aw_burst;
      r_cnt   <= '0;
      r_err   <= w_aw_err;
    end else if (w_w_hs) begin
      r_addr <= w_next_addr;
      r_cnt  <= r_cnt + 8'd1;
      if (!w_last && r_cnt == r_len) r_err <= 1'b1;
    end
  end
  // AW acceptance reserves a slot, so a push never finds the FIFO full
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < B_DEPTH; i++) r_fifo[i] <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_bcnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= {r_id, (r_err | (r_cnt != r_len)) ? RESP_SLVERR : RESP_OKAY};
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_bcnt <= r_bcnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end
  assign b_valid         = (r_bcnt != '0);
  assign {b_id, b_resp}  = r_fifo[r_rp];
  assign mem_we          = w_w_hs & ~r_err;
  assign mem_addr        = r_addr;
  assign mem_wdata       = w_data;
  assign mem_wstrb       = w_strb;
endmodule

// File: tb/tb_axi4_wr_burst_engine.sv
// tb_axi4_wr_burst_engine: directed checks of burst address generation, error handling and the B FIFO
module tb_axi4_wr_burst_engine;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  aw_id = '0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        aw_valid = 1'b0, aw_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_last = 1'b0, w_valid = 1'b0, w_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready = 1'b0;
  logic        mem_we, mem_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  axi4_wr_burst_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .B_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output logic ok);
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !aw_ready; i++) tick;
    ok = aw_ready;
    if (ok) tick;
    aw_valid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last,
                        output logic ok, output logic we, output logic [31:0] a);
    w_data = d; w_strb = s; w_last = last; w_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !w_ready; i++) tick;
    ok = w_ready; we = mem_we; a = mem_addr;
    if (ok) tick;
    w_valid = 1'b0; w_last = 1'b0;
  endtask
  task automatic pop_b;
    b_ready = 1'b1;
    tick;
    b_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++; if (aw_ready !== 1'b0) begin errors++; $display("FAIL reset_aw_ready: got %b exp 0", aw_ready); end
    checks++; if ({w_ready, b_valid, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b exp 000", {w_ready, b_valid, mem_we}); end
    checks++; if ({b_id, b_resp} !== 6'h00) begin errors++; $display("FAIL reset_b: got %h exp 00", {b_id, b_resp}); end
    rst = 1'b0;
    tick;
    checks++; if (aw_ready !== 1'b1) begin errors++; $display("FAIL idle_aw_ready: got %b exp 1", aw_ready); end
  endtask
  task automatic test_incr;
    logic ok, we;
    logic [31:0] a;
    logic [31:0] ea [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    send_aw(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL incr_aw: got %b exp 1", ok); end
    for (int b = 0; b < 4; b++) begin
      send_w(32'hA0 + b, 4'hF, b == 3, ok, we, a);
      checks++; if ({ok, we, a} !== {2'b11, ea[b]}) begin errors++; $display("FAIL incr_beat%0d: got ok=%b we=%b addr=%h exp 1 1 %h", b, ok, we, a, ea[b]); end
    end
    checks++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd5, 2'b00}) begin errors++; $display("FAIL incr_b: got v=%b id=%0d resp=%0d exp 1 5 0", b_valid, b_id, b_resp); end
    pop_b;
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL incr_b_empty: got %b exp 0", b_valid); end
  endtask
  task automatic test_wrap;
    logic ok, we;
    logic [31:0] a;
    logic [31:0] ew [4] = '{32'h108, 32'h10C, 32'h100, 32'h104};
    logic [31:0] eu [4] = '{32'h102, 32'h104, 32'h108, 32'h10C};
    send_aw(4'd2, 32'h108, 8'd3, 3'd2, 2'b10, ok);
    for (int b = 0; b < 4; b++) begin
      send_w(32'hB0 + b, 4'hF, b == 3, ok, we, a);
      checks++; if ({ok, we, a} !== {2'b11, ew[b]}) begin errors++; $display("FAIL wrap_beat%0d: got ok=%b we=%b addr=%h exp 1 1 %h", b, ok, we, a, ew[b]); end
    end
    checks++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd2, 2'b00}) begin errors++; $display("FAIL wrap_b: got v=%b id=%0d resp=%0d exp 1 2 0", b_valid, b_id, b_resp); end
    pop_b;
    send_aw(4'd3, 32'h102, 8'd3, 3'd2, 2'b01, ok);
    for (int b = 0; b < 4; b++) begin
      send_w(32'hC0 + b, 4'hF, b == 3, ok, we, a);
      checks++; if ({ok, we, a} !== {2'b11, eu[b]}) begin errors++; $display("FAIL unaligned_beat%0d: got ok=%b we=%b addr=%h exp 1 1 %h", b, ok, we, a, eu[b]); end
    end
    checks++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd3, 2'b00}) begin errors++; $display("FAIL unaligned_b: got v=%b id=%0d resp=%0d exp 1 3 0", b_valid, b_id, b_resp); end
    pop_b;
  endtask
  task automatic test_fixed_stall;
    logic ok;
    send_aw(4'd7, 32'h40, 8'd2, 3'd2, 2'b00, ok);
    for (int b = 0; b < 3; b++) begin
      w_data = 32'hD0 + b; w_strb = 4'h3; w_last = (b == 2); w_valid = 1'b1; mem_ready = 1'b0;
      #1;
      checks++; if ({w_ready, mem_we} !== 2'b00) begin errors++; $display("FAIL fixed_stall%0d: got rdy=%b we=%b exp 0 0", b, w_ready, mem_we); end
      tick;
      mem_ready = 1'b1;
      #1;
      checks++; if ({w_ready, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {2'b11, 32'h40, 4'h3, 32'hD0 + b}) begin
        errors++; $display("FAIL fixed_beat%0d: got rdy=%b we=%b addr=%h strb=%h data=%h exp 1 1 40 3 %h", b, w_ready, mem_we, mem_addr, mem_wstrb, mem_wdata, 32'hD0 + b);
      end
      tick;
    end
    w_valid = 1'b0; w_last = 1'b0;
    checks++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd7, 2'b00}) begin errors++; $display("FAIL fixed_b: got v=%b id=%0d resp=%0d exp 1 7 0", b_valid, b_id, b_resp); end
    pop_b;
  endtask
  task automatic test_errors;
    logic ok, we;
    logic [31:0] a;
    logic [3:0]  ids [4] = '{4'd6, 4'd8, 4'd9, 4'd10};
    logic [31:0] ads [4] = '{32'h200, 32'h200, 32'h200, 32'h102};
    logic [7:0]  lns [4] = '{8'd2, 8'd1, 8'd0, 8'd3};
    logic [2:0]  szs [4] = '{3'd2, 3'd2, 3'd3, 3'd2};
    logic [1:0]  bts [4] = '{2'b10, 2'b11, 2'b01, 2'b10};
    mem_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      send_aw(ids[t], ads[t], lns[t], szs[t], bts[t], ok);
      for (int b = 0; b <= int'(lns[t]); b++) begin
        send_w(32'hE0, 4'hF, b == int'(lns[t]), ok, we, a);
        checks++; if ({ok, we} !== 2'b10) begin errors++; $display("FAIL err%0d_beat%0d: got ok=%b we=%b exp 1 0", t, b, ok, we); end
      end
      checks++; if ({b_valid, b_id, b_resp} !== {1'b1, ids[t], 2'b10}) begin errors++; $display("FAIL err%0d_b: got v=%b id=%0d resp=%0d exp 1 %0d 2", t, b_valid, b_id, b_resp, ids[t]); end
      pop_b;
    end
    mem_ready = 1'b1;
  endtask
  task automatic test_last_mismatch;
    logic ok, we;
    logic [31:0] a;
    send_aw(4'd4, 32'h300, 8'd3, 3'd2, 2'b01, ok);
    send_w(32'h1, 4'hF, 1'b0, ok, we, a);
    send_w(32'h2, 4'hF, 1'b1, ok, we, a);
    checks++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd4, 2'b10}) begin errors++; $display("FAIL early_b: got v=%b id=%0d resp=%0d exp 1 4 2", b_valid, b_id, b_resp); end
    checks++; if ({aw_ready, w_ready} !== 2'b10) begin errors++; $display("FAIL early_idle: got aw=%b w=%b exp 1 0", aw_ready, w_ready); end
    pop_b;
    send_aw(4'd11, 32'h400, 8'd1, 3'd2, 2'b01, ok);
    send_w(32'h3, 4'hF, 1'b0, ok, we, a);
    checks++; if ({ok, we, a} !== {2'b11, 32'h400}) begin errors++; $display("FAIL late_beat0: got ok=%b we=%b addr=%h exp 1 1 400", ok, we, a); end
    send_w(32'h4, 4'hF, 1'b0, ok, we, a);
    checks++; if ({ok, we, a} !== {2'b11, 32'h404}) begin errors++; $display("FAIL late_beat1: got ok=%b we=%b addr=%h exp 1 1 404", ok, we, a); end
    send_w(32'h5, 4'hF, 1'b1, ok, we, a);
    checks++; if ({ok, we} !== 2'b10) begin errors++; $display("FAIL late_beat2: got ok=%b we=%b exp 1 0", ok, we); end
    checks++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd11, 2'b10}) begin errors++; $display("FAIL late_b: got v=%b id=%0d resp=%0d exp 1 11 2", b_valid, b_id, b_resp); end
    pop_b;
  endtask
  task automatic test_back_to_back;
    logic ok, we;
    logic [31:0] a;
    for (int i = 1; i <= 4; i++) begin
      send_aw(4'(i), 32'h500 + 32'(16 * i), 8'd0, 3'd2, 2'b01, ok);
      send_w(32'(i), 4'hF, 1'b1, ok, we, a);
      checks++; if ({ok, we} !== 2'b11) begin errors++; $display("FAIL b2b_burst%0d: got ok=%b we=%b exp 1 1", i, ok, we); end
    end
    aw_id = 4'd5; aw_addr = 32'h550; aw_len = 8'd0; aw_burst = 2'b01; aw_valid = 1'b1;
    tick; tick;
    checks++; if (aw_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got aw_ready=%b exp 0", aw_ready); end
    pop_b;
    checks++; if (aw_ready !== 1'b1) begin errors++; $display("FAIL b2b_slot: got aw_ready=%b exp 1", aw_ready); end
    send_aw(4'd5, 32'h550, 8'd0, 3'd2, 2'b01, ok);
    send_w(32'h5, 4'hF, 1'b1, ok, we, a);
    checks++; if ({ok, we} !== 2'b11) begin errors++; $display("FAIL b2b_burst5: got ok=%b we=%b exp 1 1", ok, we); end
    for (int i = 2; i <= 5; i++) begin
      checks++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'(i), 2'b00}) begin errors++; $display("FAIL b2b_order%0d: got v=%b id=%0d resp=%0d exp 1 %0d 0", i, b_valid, b_id, b_resp, i); end
      pop_b;
    end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b exp 0", b_valid); end
  endtask
  task automatic test_reset_mid;
    logic ok, we;
    logic [31:0] a;
    send_aw(4'd12, 32'h600, 8'd3, 3'd2, 2'b01, ok);
    send_w(32'h6, 4'hF, 1'b0, ok, we, a);
    w_valid = 1'b1; rst = 1'b1;
    tick;
    checks++; if ({aw_ready, w_ready, b_valid, mem_we} !== 4'b0000) begin errors++; $display("FAIL rstmid_outs: got %b exp 0000", {aw_ready, w_ready, b_valid, mem_we}); end
    rst = 1'b0; w_valid = 1'b0;
    tick;
    checks++; if ({aw_ready, b_valid} !== 2'b10) begin errors++; $display("FAIL rstmid_idle: got aw=%b bv=%b exp 1 0", aw_ready, b_valid); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_incr;
    test_wrap;
    test_fixed_stall;
    test_errors;
    test_last_mismatch;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
